// File: rtl/sdf_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_butterfly
//  Description : Radix-2 single-path delay-feedback (DIF) butterfly stage,
//                no twiddle multiply. Emits sums in the second half-frame and
//                the matching differences in the next frame's first half.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdf_butterfly #(
    parameter int IN_W  = 10,
    parameter int DELAY = 4,
    localparam int OUT_W = IN_W + 1,
    localparam int IDX_W = $clog2(2 * DELAY)
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_init,
    input  logic                    i_vld,
    input  logic signed [IN_W-1:0]  i_re,
    input  logic signed [IN_W-1:0]  i_im,
    output logic                    o_vld,
    output logic signed [OUT_W-1:0] o_re,
    output logic signed [OUT_W-1:0] o_im,
    output logic [IDX_W-1:0]        o_idx
);

    // DELAY is a power of two, so the counter MSB alone marks the second half.
    localparam logic [IDX_W-1:0] c_phase_bit = IDX_W'(DELAY);
    localparam logic [IDX_W-1:0] c_last_a    = IDX_W'(DELAY - 1);
    localparam logic [IDX_W-1:0] c_last      = IDX_W'(2 * DELAY - 1);

    logic [IDX_W-1:0]        r_cnt;
    logic                    r_primed;
    logic signed [OUT_W-1:0] r_dl_re [DELAY];
    logic signed [OUT_W-1:0] r_dl_im [DELAY];

    logic                    w_accept;
    logic                    w_phase_b;
    logic                    w_out_vld;
    logic [IDX_W-1:0]        w_cnt_next;
    logic [IDX_W-1:0]        w_out_idx;
    logic signed [OUT_W-1:0] w_in_re,   w_in_im;
    logic signed [OUT_W-1:0] w_head_re, w_head_im;
    logic signed [OUT_W-1:0] w_push_re, w_push_im;
    logic signed [OUT_W-1:0] w_out_re,  w_out_im;

    assign w_accept   = i_vld & ~i_init;
    assign w_phase_b  = r_cnt[IDX_W-1];
    assign w_in_re    = {i_re[IN_W-1], i_re};
    assign w_in_im    = {i_im[IN_W-1], i_im};
    assign w_head_re  = r_dl_re[DELAY-1];
    assign w_head_im  = r_dl_im[DELAY-1];
    assign w_cnt_next = (r_cnt == c_last) ? '0 : r_cnt + IDX_W'(1);
    // Sums carry k = cnt-DELAY (MSB clear); differences carry DELAY+k (MSB set).
    assign w_out_idx  = r_cnt ^ c_phase_bit;
    assign w_out_vld  = w_accept & (w_phase_b | r_primed);

    always_comb begin
        w_push_re = w_in_re;
        w_push_im = w_in_im;
        w_out_re  = w_head_re;
        w_out_im  = w_head_im;
        if (w_phase_b) begin
            w_push_re = w_head_re - w_in_re;
            w_push_im = w_head_im - w_in_im;
            w_out_re  = w_head_re + w_in_re;
            w_out_im  = w_head_im + w_in_im;
        end
    end

    // Delay-line contents are never observable until refilled after reset/init.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = DELAY - 1; k > 0; k--) begin
                r_dl_re[k] <= r_dl_re[k-1];
                r_dl_im[k] <= r_dl_im[k-1];
            end
            r_dl_re[0] <= w_push_re;
            r_dl_im[0] <= w_push_im;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            o_vld    <= 1'b0;
            o_re     <= '0;
            o_im     <= '0;
            o_idx    <= '0;
        end else if (i_init) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            o_vld    <= 1'b0;
        end else begin
            o_vld <= w_out_vld;
            if (w_accept) begin
                r_cnt <= w_cnt_next;
                if (r_cnt == c_last_a) begin
                    r_primed <= 1'b1;
                end
            end
            if (w_out_vld) begin
                o_re  <= w_out_re;
                o_im  <= w_out_im;
                o_idx <= w_out_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdf_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdf_butterfly
//  Description : Vector table + scoreboard bench for sdf_butterfly
//                (DELAY=2 main instance, DELAY=1 secondary instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_butterfly;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_reset = 1'b0;
    logic              i_init  = 1'b0;
    logic              i_vld   = 1'b0;
    logic signed [7:0] i_re    = '0;
    logic signed [7:0] i_im    = '0;
    logic              o_vld;
    logic signed [8:0] o_re, o_im;
    logic [1:0]        o_idx;

    logic              d1_init = 1'b0;
    logic              d1_vld  = 1'b0;
    logic signed [7:0] d1_re   = '0;
    logic signed [7:0] d1_im   = '0;
    logic              d1_o_vld;
    logic signed [8:0] d1_o_re, d1_o_im;
    logic [0:0]        d1_o_idx;

    sdf_butterfly #(.IN_W(8), .DELAY(2)) u_dut (
        .clk(clk), .i_reset(i_reset), .i_init(i_init), .i_vld(i_vld),
        .i_re(i_re), .i_im(i_im),
        .o_vld(o_vld), .o_re(o_re), .o_im(o_im), .o_idx(o_idx)
    );

    sdf_butterfly #(.IN_W(8), .DELAY(1)) u_dut_d1 (
        .clk(clk), .i_reset(i_reset), .i_init(d1_init), .i_vld(d1_vld),
        .i_re(d1_re), .i_im(d1_im),
        .o_vld(d1_o_vld), .o_re(d1_o_re), .o_im(d1_o_im), .o_idx(d1_o_idx)
    );

    typedef struct {
        logic              vld;
        logic              init;
        logic signed [7:0] re;
        logic signed [7:0] im;
        logic              ev;
        logic signed [8:0] er;
        logic signed [8:0] ei;
        logic [1:0]        ex;
    } vec_t;

    typedef struct {
        int                cyc;
        logic signed [8:0] re;
        logic signed [8:0] im;
        logic [1:0]        idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic void add(input logic vld, input logic init, input int re, input int im,
                                input logic ev, input int er, input int ei, input int ex);
        vec_t t;
        t.vld = vld; t.init = init; t.re = 8'(re); t.im = 8'(im);
        t.ev = ev; t.er = 9'(er); t.ei = 9'(ei); t.ex = 2'(ex);
        vecs.push_back(t);
    endfunction

    function automatic void s(input int re, input int im, input logic ev,
                              input int er, input int ei, input int ex);
        add(1'b1, 1'b0, re, im, ev, er, ei, ex);
    endfunction

    function automatic void gap(input int n);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 99, -99, 1'b0, 0, 0, 0);
    endfunction

    function automatic void ini(input logic vld);
        add(vld, 1'b1, 50, -50, 1'b0, 0, 0, 0);
    endfunction

    task automatic drive(input vec_t t);
        exp_t e;
        @(negedge clk);
        i_vld  = t.vld;
        i_init = t.init;
        i_re   = t.re;
        i_im   = t.im;
        if (t.ev) begin
            e.cyc = cyc + 1; e.re = t.er; e.im = t.ei; e.idx = t.ex;
            sb.push_back(e);
        end
    endtask

    // Pops the scoreboard on every o_vld pulse and checks hold otherwise.
    task automatic monitor_loop();
        exp_t              e;
        logic signed [8:0] p_re  = '0;
        logic signed [8:0] p_im  = '0;
        logic [1:0]        p_idx = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (i_reset) begin
                p_re = '0; p_im = '0; p_idx = '0;
            end else if (o_vld) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_vld cyc=%0d got re=%0d im=%0d idx=%0d want no output",
                             cyc, o_re, o_im, o_idx);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || o_re != e.re || o_im != e.im || o_idx != e.idx) begin
                        errors++;
                        $display("FAIL output cyc=%0d got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d at cyc=%0d",
                                 cyc, o_re, o_im, o_idx, e.re, e.im, e.idx, e.cyc);
                    end
                end
                p_re = o_re; p_im = o_im; p_idx = o_idx;
            end else begin
                checks++;
                if (o_re != p_re || o_im != p_im || o_idx != p_idx) begin
                    errors++;
                    $display("FAIL hold cyc=%0d got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                             cyc, o_re, o_im, o_idx, p_re, p_im, p_idx);
                end
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    e = sb.pop_front();
                    $display("FAIL missing_vld cyc=%0d got vld=0 want re=%0d im=%0d idx=%0d",
                             cyc, e.re, e.im, e.idx);
                end
            end
        end
    endtask

    int                d1_ev  [4] = '{0, 1, 1, 1};
    int                d1_er  [4] = '{0, 3, -1, 7};
    int                d1_ex  [4] = '{0, 0, 1, 0};

    initial begin
        // Continuous stream straight out of reset.
        s(1, 0, 0, 0, 0, 0);  s(2, 0, 0, 0, 0, 0);
        s(3, 0, 1, 4, 0, 0);  s(4, 0, 1, 6, 0, 1);
        s(5, 0, 1, -2, 0, 2); s(6, 0, 1, -2, 0, 3);
        gap(1);
        // Same stream with 3-cycle gaps after an init that arrives with i_vld high.
        ini(1'b1);
        s(1, 0, 0, 0, 0, 0);  gap(3); s(2, 0, 0, 0, 0, 0);  gap(3);
        s(3, 0, 1, 4, 0, 0);  gap(3); s(4, 0, 1, 6, 0, 1);  gap(3);
        s(5, 0, 1, -2, 0, 2); gap(3); s(6, 0, 1, -2, 0, 3); gap(3);
        // Extremes of the input range on both components.
        ini(1'b0);
        s(127, -128, 0, 0, 0, 0);    s(-128, 127, 0, 0, 0, 0);
        s(127, -128, 1, 254, -256, 0); s(-127, 126, 1, -255, 253, 1);
        s(0, 0, 1, 0, 0, 2);         s(0, 0, 1, -1, 1, 3);
        gap(1);
        // Init in mid-frame after priming: must re-gate the first Phase A.
        ini(1'b1);
        s(1, 0, 0, 0, 0, 0);  s(2, 0, 0, 0, 0, 0);
        s(3, 0, 1, 4, 0, 0);  s(4, 0, 1, 6, 0, 1);  s(5, 0, 1, -2, 0, 2);
        ini(1'b1);
        s(7, 3, 0, 0, 0, 0);  s(8, -5, 0, 0, 0, 0);
        s(9, 1, 1, 16, 4, 0); s(10, 2, 1, 18, -3, 1);
        s(11, 0, 1, -2, 2, 2); s(12, 0, 1, -2, -7, 3);
        gap(2);

        #1 i_reset = 1'b1;
        #2;
        checks++;
        if (o_vld !== 1'b0 || o_re !== 9'sd0 || o_im !== 9'sd0 || o_idx !== 2'd0 ||
            d1_o_vld !== 1'b0 || d1_o_re !== 9'sd0 || d1_o_im !== 9'sd0 || d1_o_idx !== 1'd0) begin
            errors++;
            $display("FAIL reset_state got vld=%b re=%0d im=%0d idx=%0d d1 vld=%b re=%0d want all zero",
                     o_vld, o_re, o_im, o_idx, d1_o_vld, d1_o_re);
        end
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        fork
            monitor_loop();
        join_none

        foreach (vecs[n]) drive(vecs[n]);

        // Asynchronous reset right after a sum was emitted, then a fresh frame.
        vecs.delete();
        ini(1'b1);
        s(1, 0, 0, 0, 0, 0); s(2, 0, 0, 0, 0, 0); s(3, 0, 1, 4, 0, 0);
        gap(1);
        foreach (vecs[n]) drive(vecs[n]);
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_re !== 9'sd0 || o_im !== 9'sd0 || o_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got vld=%b re=%0d im=%0d idx=%0d want 0 0 0 0",
                     o_vld, o_re, o_im, o_idx);
        end
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        vecs.delete();
        s(10, 0, 0, 0, 0, 0); s(20, 0, 0, 0, 0, 0);
        s(30, 0, 1, 40, 0, 0); s(40, 0, 1, 60, 0, 1);
        gap(2);
        foreach (vecs[n]) drive(vecs[n]);

        // DELAY=1 instance: alternating sum / difference every sample.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d1_vld = 1'b1;
            d1_re  = 8'(k + 1);
            d1_im  = '0;
            @(posedge clk);
            #1;
            checks++;
            if (d1_o_vld !== d1_ev[k][0] ||
                (d1_ev[k] != 0 && (d1_o_re != 9'(d1_er[k]) || d1_o_im != 9'sd0 ||
                                   d1_o_idx != 1'(d1_ex[k])))) begin
                errors++;
                $display("FAIL d1_sample%0d got vld=%b re=%0d im=%0d idx=%0d want vld=%0d re=%0d im=0 idx=%0d",
                         k, d1_o_vld, d1_o_re, d1_o_im, d1_o_idx, d1_ev[k], d1_er[k], d1_ex[k]);
            end
        end
        @(negedge clk);
        d1_vld = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending outputs want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdf_butterfly.md
SDF_BUTTERFLY -- requirements
Module: sdf_butterfly

Interface
REQ-001 Parameter IN_W, default 10, signed width of each input component.
REQ-002 Parameter DELAY, default 4, feedback depth in samples (half-frame length); SHALL be a power of two, >= 1.
REQ-003 Derived widths: OUT_W = IN_W+1; IDX_W = $clog2(2*DELAY).
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_init  input  1  synchronous frame-restart/flush, active-high.
REQ-007 i_vld  input  1  input sample valid; one sample per cycle at most.
REQ-008 i_re, i_im  input  IN_W each  signed real/imag input sample.
REQ-009 o_vld  output  1  output sample valid (registered).
REQ-010 o_re, o_im  output  OUT_W each  signed butterfly result (registered); feeds round stage.
REQ-011 o_idx  output  IDX_W  index of output within its output frame (registered), for downstream twiddle select.

Function
REQ-012 Block SHALL implement one radix-2 single-path delay-feedback (DIF) butterfly stage, no twiddle multiply.
REQ-013 Accepted sample: i_vld=1 and i_init=0; only accepted samples advance any state.
REQ-014 Counter cnt (IDX_W bits) SHALL increment per accepted sample and wrap 2*DELAY-1 -> 0.
REQ-015 Delay line: DELAY complex entries, OUT_W bits per component, shifts only on accepted samples.
REQ-016 Phase A (cnt < DELAY): push sign-extended input; head entry (difference from previous frame) is output.
REQ-017 Phase B (cnt >= DELAY): a = head, b = input; output a+b; push a-b.
REQ-018 Arithmetic full precision at OUT_W bits, two's complement, no saturation/rounding; cannot overflow.
REQ-019 Latency: output registered one cycle after the accepted sample producing it.
REQ-020 o_idx: Phase B output -> cnt-DELAY (sum k, MSB=0); Phase A output -> cnt (difference k, MSB=1).
REQ-021 Flag primed SHALL set when cnt wraps from DELAY-1 to DELAY first time after reset/init; Phase A outputs gated until a full Phase B has completed (i.e. first frame's Phase A produces o_vld=0).
REQ-022 o_vld = 1 on cycle after an accepted sample in Phase B, or in Phase A with primed=1; else 0.
REQ-023 o_re/o_im/o_idx SHALL hold their previous value when o_vld would be 0.
REQ-024 i_vld gaps of any length SHALL not corrupt frame alignment or data.
REQ-025 Last frame's differences emerge only when the next frame's Phase A samples arrive (no auto-flush).
REQ-026 i_init=1 (regardless of i_vld): next cycle cnt=0, primed=0, o_vld=0; input ignored; delay contents don't-care.

Reset
REQ-027 i_reset=1 SHALL immediately clear cnt, primed, o_vld, o_re, o_im, o_idx to 0, independent of clk.
REQ-028 Delay-line storage need not be reset; gating by primed SHALL prevent stale data reaching o_vld=1.
REQ-029 Reset deassertion mid-stream: first accepted sample afterwards is sample 0 of frame.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; no outputs from it after release.

Verification (IN_W=8, DELAY=2 unless noted)
REQ-031 Continuous re 1,2,3,4,5,6, im 0 -> o_vld low for first two; then re 4 (idx0), 6 (idx1), -2 (idx2), -2 (idx3), each one cycle after inputs 3,4,5,6.
REQ-032 Same stream with i_vld deasserted 3 cycles between every sample -> identical output values/idx sequence, o_vld pulses one cycle after each producing input, outputs held in gaps.
REQ-033 Extremes: re 127,-128 then 127,-127 -> sums 254, -255; diffs 0, -1 next frame; no wrap.
REQ-034 i_reset pulse after input 3 -> all outputs 0 immediately; then 10,20,30,40 -> o_vld low for 10,20; sums 40, 60.
REQ-035 i_init high with i_vld high after input 2 -> o_vld 0 next cycle; following 7,8,9,10 -> sums 16, 18, idx 0,1.
REQ-036 DELAY=1: re 1,2,3,4 -> outputs 3 (idx0), -1 (idx1), 7 (idx0).
